// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared constants for the sequential ALU.
//   Opcode encodings, status-flag bit positions and FSM state encodings.
//   The BUSY state only exists when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  // status = {C, Z, Nf, V, P}
  localparam int FLAG_C  = 4;
  localparam int FLAG_Z  = 3;
  localparam int FLAG_NF = 2;
  localparam int FLAG_V  = 1;
  localparam int FLAG_P  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef ALU_SEQ_MUL_EN
    ,
    S_BUSY = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core -- single-cycle combinational datapath for opcodes 0..14.
//   a_i, b_i  : operands (two's complement)
//   opcode_i  : operation select
//   y_o       : N-bit result
//   status_o  : {C, Z, Nf, V, P}
// Opcode 15 (MUL) is not handled here; it yields y_o=0, status_o=5'b01000.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   opcode_i,
  output logic [N-1:0] y_o,
  output logic [4:0]   status_o
);

  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};

  logic [N:0]   sum_s;
  logic [N:0]   diff_s;
  logic [N:0]   inc_s;
  logic [N:0]   dec_s;
  logic [N-1:0] y_s;
  logic [N-1:0] flag_src_s;
  logic         carry_s;
  logic         ovf_s;
  logic         cmp_s;

  function automatic logic parity_of(input logic [N-1:0] v);
    parity_of = ^v;
  endfunction

  // The extra top bit of each N+1-bit result is the carry/borrow out.
  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};
  assign inc_s  = {1'b0, a_i} + {{N{1'b0}}, 1'b1};
  assign dec_s  = {1'b0, a_i} - {{N{1'b0}}, 1'b1};

  // Operation decode: result, carry and overflow per opcode
  always_comb begin
    y_s     = {N{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    cmp_s   = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        y_s     = sum_s[N-1:0];
        carry_s = sum_s[N];
        ovf_s   = (a_i[N-1] == b_i[N-1]) && (sum_s[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        y_s     = diff_s[N-1:0];
        carry_s = diff_s[N];
        ovf_s   = (a_i[N-1] != b_i[N-1]) && (diff_s[N-1] != a_i[N-1]);
      end
      OP_AND:  y_s = a_i & b_i;
      OP_OR:   y_s = a_i | b_i;
      OP_XOR:  y_s = a_i ^ b_i;
      OP_NOT:  y_s = ~a_i;
      OP_SHL: begin
        y_s     = {a_i[N-2:0], 1'b0};
        carry_s = a_i[N-1];
      end
      OP_SHR: begin
        y_s     = {1'b0, a_i[N-1:1]};
        carry_s = a_i[0];
      end
      OP_SAR: begin
        y_s     = {a_i[N-1], a_i[N-1:1]};
        carry_s = a_i[0];
      end
      OP_ROL: begin
        y_s     = {a_i[N-2:0], a_i[N-1]};
        carry_s = a_i[N-1];
      end
      OP_ROR: begin
        y_s     = {a_i[0], a_i[N-1:1]};
        carry_s = a_i[0];
      end
      OP_INC: begin
        y_s     = inc_s[N-1:0];
        carry_s = inc_s[N];
        ovf_s   = (a_i == ~MSB_ONLY);
      end
      OP_DEC: begin
        y_s     = dec_s[N-1:0];
        carry_s = dec_s[N];
        ovf_s   = (a_i == MSB_ONLY);
      end
      OP_PASS: y_s = b_i;
      OP_CMP: begin
        // Y passes A through; every flag describes A-B.
        y_s     = a_i;
        carry_s = diff_s[N];
        ovf_s   = (a_i[N-1] != b_i[N-1]) && (diff_s[N-1] != a_i[N-1]);
        cmp_s   = 1'b1;
      end
      default: y_s = {N{1'b0}};
    endcase
  end

  assign flag_src_s = cmp_s ? diff_s[N-1:0] : y_s;
  assign y_o        = y_s;

  // Pack the status flags
  always_comb begin
    status_o          = 5'b00000;
    status_o[FLAG_C]  = carry_s;
    status_o[FLAG_Z]  = (flag_src_s == {N{1'b0}});
    status_o[FLAG_NF] = flag_src_s[N-1];
    status_o[FLAG_V]  = ovf_s;
    status_o[FLAG_P]  = parity_of(flag_src_s);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (A, B, Opcode captured on accept)
//   out_valid/out_ready : result handshake (Y, status held until taken)
//   Y, status           : registered result and {C, Z, Nf, V, P}
// Optional feature macro ALU_SEQ_MUL_EN: when defined, opcode 15 is an
// N-cycle shift-add multiply (BUSY state); otherwise it completes in one
// cycle with Y=0, status=5'b01000.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   Opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [4:0]   status
);

  state_e       state_q, state_d;
  state_e       accept_next_s;
  logic         accept_s;
  logic         is_mul_s;
  logic [N-1:0] core_y_s;
  logic [4:0]   core_status_s;
  logic [N-1:0] y_q, y_d;
  logic [4:0]   status_q, status_d;

  alu_seq_core #(.N(N)) u_core (
    .a_i      (A),
    .b_i      (B),
    .opcode_i (Opcode),
    .y_o      (core_y_s),
    .status_o (core_status_s)
  );

  assign accept_s = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(N + 1);

  // acc_q holds {partial product high half, remaining multiplier bits}.
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     part_sum_s;
  logic           mul_done_s;
  logic [N-1:0]   mul_y_s;
  logic [4:0]     mul_status_s;

  assign is_mul_s      = (Opcode == OP_MUL);
  assign accept_next_s = is_mul_s ? S_BUSY : S_HOLD;
  // After N iterations the counter parks at N for one cycle while Y loads.
  assign mul_done_s    = (state_q == S_BUSY) && (cnt_q == CW'(N));
  assign part_sum_s    = {1'b0, acc_q[2*N-1:N]} +
                         (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
  assign mul_y_s       = acc_q[N-1:0];
  // {C = any high product bit, Z, Nf, V = 0, P}
  assign mul_status_s  = {|acc_q[2*N-1:N], (mul_y_s == {N{1'b0}}),
                          mul_y_s[N-1], 1'b0, ^mul_y_s};

  // Multiplier next state: load on accept, one shift-add step per BUSY cycle
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (accept_s && is_mul_s) begin
      acc_d   = {{N{1'b0}}, A};
      mcand_d = B;
      cnt_d   = {CW{1'b0}};
    end else if ((state_q == S_BUSY) && !mul_done_s) begin
      acc_d   = {part_sum_s, acc_q[N-1:1]};
      cnt_d   = cnt_q + CW'(1);
    end else begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
    end
  end

  // Multiplier registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= {(2*N){1'b0}};
      mcand_q <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign is_mul_s      = 1'b0;
  assign accept_next_s = S_HOLD;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = accept_next_s;
        else          state_d = S_IDLE;
      end
      S_HOLD: begin
        if (accept_s)       state_d = accept_next_s;
        else if (out_ready) state_d = S_IDLE;
        else                state_d = S_HOLD;
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (mul_done_s) state_d = S_HOLD;
        else            state_d = S_BUSY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = (state_q == S_HOLD);
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    end
  end

  // Result register next value: load on single-cycle accept or multiply finish
  always_comb begin
    y_d      = y_q;
    status_d = status_q;
    if (accept_s && !is_mul_s) begin
      y_d      = core_y_s;
      status_d = core_status_s;
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_done_s) begin
      y_d      = mul_y_s;
      status_d = mul_status_s;
`endif
    end else begin
      y_d      = y_q;
      status_d = status_q;
    end
  end

  // Result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= {N{1'b0}};
      status_q <= 5'b00000;
    end else begin
      y_q      <= y_d;
      status_q <= status_d;
    end
  end

  assign Y      = y_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (N=8).
// A transaction-level reference model predicts handshake and result values;
// a compare process checks them every cycle, and directed sections pin
// hand-computed literals. Works with or without ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int N = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   Opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic [4:0]   status;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Opcode    (Opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic written directly from the operation definitions.
  task automatic ref_op(input longint a, input longint b, input int op,
                        output logic [N-1:0] y, output logic [4:0] st);
    longint mask, sa, sb, smax, smin, full, f;
    logic c, v;
    logic [N-1:0] fb;
    mask = (longint'(1) << N) - 1;
    smax = (longint'(1) << (N - 1)) - 1;
    smin = -(longint'(1) << (N - 1));
    sa = (a > smax) ? a - (mask + 1) : a;
    sb = (b > smax) ? b - (mask + 1) : b;
    c = 1'b0;
    v = 1'b0;
    f = 0;
    case (op)
      0:  begin full = a + b; f = full & mask; c = (full > mask);
                v = ((sa + sb) > smax) || ((sa + sb) < smin); end
      1, 14: begin f = (a - b) & mask; c = (a < b);
                v = ((sa - sb) > smax) || ((sa - sb) < smin); end
      2:  f = a & b;
      3:  f = a | b;
      4:  f = a ^ b;
      5:  f = (~a) & mask;
      6:  begin f = (a << 1) & mask; c = ((a >> (N - 1)) & 1) != 0; end
      7:  begin f = a >> 1; c = (a & 1) != 0; end
      8:  begin f = (sa >>> 1) & mask; c = (a & 1) != 0; end
      9:  begin f = ((a << 1) | (a >> (N - 1))) & mask; c = ((a >> (N - 1)) & 1) != 0; end
      10: begin f = (a >> 1) | ((a & 1) << (N - 1)); c = (a & 1) != 0; end
      11: begin f = (a + 1) & mask; c = (a == mask); v = (sa + 1 > smax); end
      12: begin f = (a - 1) & mask; c = (a == 0); v = (sa - 1 < smin); end
      13: f = b;
      default: begin
        if (MUL_ON) begin
          full = a * b; f = full & mask; c = ((full >> N) != 0);
        end else begin
          f = 0;
        end
      end
    endcase
    fb = f[N-1:0];
    y  = (op == 14) ? a[N-1:0] : fb;
    st = {c, (fb == '0), fb[N-1], v, ^fb};
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid;
  logic [N-1:0] m_y, p_y, r_y;
  logic [4:0]   m_st, p_st, r_st;
  int           m_wait;
  logic         took;
  logic         exp_in_ready;

  assign exp_in_ready = !rst && (m_wait == 0) && (!m_valid || out_ready);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_y = '0; m_st = '0; m_wait = 0;
    end else begin
      took = in_valid && exp_in_ready;
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_y = p_y; m_st = p_st;
        end
      end else if (took) begin
        ref_op(longint'(A), longint'(B), int'(Opcode), r_y, r_st);
        if (MUL_ON && (Opcode == OP_MUL)) begin
          m_wait = N + 1; p_y = r_y; p_st = r_st; m_valid = 1'b0;
        end else begin
          m_valid = 1'b1; m_y = r_y; m_st = r_st;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of DUT against the model
  bit run_chk = 1'b0;
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_in_ready", in_ready, exp_in_ready);
      chk("cyc_y", Y, m_y);
      chk("cyc_status", status, m_st);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic req(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op);
    in_valid = 1'b1; A = a; B = b; Opcode = op;
  endtask

  function automatic logic [N-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return {N{1'b0}};
      1: return {N{1'b1}};
      2: return {1'b0, {(N-1){1'b1}}};
      3: return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  logic [N-1:0] ty;
  logic [4:0]   ts;

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Opcode = '0; out_ready = 1'b1;

    // Pin the reference model with hand-computed results
    ref_op(3, 7, 0, ty, ts);   chk("model_add_y", ty, 8'd10);   chk("model_add_st", ts, 5'b00000);
    ref_op(3, 7, 1, ty, ts);   chk("model_sub_y", ty, 8'hFC);   chk("model_sub_st", ts, 5'b10100);
    ref_op(127, 1, 0, ty, ts); chk("model_ovf_y", ty, 8'h80);   chk("model_ovf_st", ts, 5'b00111);
    ref_op(3, 7, 15, ty, ts);
    if (MUL_ON) begin chk("model_mul_y", ty, 8'd21); chk("model_mul_st", ts, 5'b00001); end
    else        begin chk("model_mul_y", ty, 8'd0);  chk("model_mul_st", ts, 5'b01000); end

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", Y, 8'd0);
    chk("rst_status", status, 5'b00000);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0; #1;
    chk("release_in_ready", in_ready, 1'b1);
    run_chk = 1'b1;

    // ADD 3+7
    tick(); req(8'd3, 8'd7, OP_ADD);
    tick(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1'b1); chk("add_y", Y, 8'd10); chk("add_st", status, 5'b00000);

    // SUB 3-7
    tick(); req(8'd3, 8'd7, OP_SUB);
    tick(); in_valid = 1'b0;
    chk("sub_y", Y, 8'hFC); chk("sub_st", status, 5'b10100);

    // Signed overflow 127+1, then retire and hold
    tick(); req(8'd127, 8'd1, OP_ADD);
    tick(); in_valid = 1'b0;
    chk("ovf_y", Y, 8'h80); chk("ovf_st", status, 5'b00111);
    tick();
    chk("retire_valid", out_valid, 1'b0); chk("retire_hold_y", Y, 8'h80);
    chk("retire_hold_st", status, 5'b00111);

`ifdef ALU_SEQ_MUL_EN
    // MUL 3*7: N+1 cycle latency, in_ready low while busy
    tick(); req(8'd3, 8'd7, OP_MUL);
    for (int i = 1; i <= N + 1; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      chk("mul_busy_valid", out_valid, 1'b0);
      chk("mul_busy_in_ready", in_ready, 1'b0);
    end
    tick();
    chk("mul_valid", out_valid, 1'b1); chk("mul_y", Y, 8'd21); chk("mul_st", status, 5'b00001);
`endif

    // Backpressure then back-to-back accept
    tick(); req(8'd3, 8'd7, OP_ADD); out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    chk("bp_valid", out_valid, 1'b1); chk("bp_y", Y, 8'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_y", Y, 8'd10);
      chk("bp_hold_st", status, 5'b00000);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; req(8'd3, 8'd7, OP_SUB); #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1'b1); chk("b2b_y", Y, 8'hFC); chk("b2b_st", status, 5'b10100);

    // Reset three cycles into a MUL
    tick(); req(8'd3, 8'd7, OP_MUL);
    tick(); in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; #1;
    chk("midrst_valid", out_valid, 1'b0); chk("midrst_y", Y, 8'd0);
    chk("midrst_in_ready", in_ready, 1'b0);
    tick(); rst = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      chk("midrst_no_result", out_valid, 1'b0);
    end
    req(8'd3, 8'd7, OP_ADD);
    tick(); in_valid = 1'b0;
    chk("after_rst_add_y", Y, 8'd10);

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 800; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 99) < 60);
      Opcode    = 4'($urandom_range(0, 15));
      A         = pick_val();
      B         = pick_val();
      out_ready = ($urandom_range(0, 99) < 70);
    end
    tick(); in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N + 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
